// File: rtl/cmp_pkg.sv
// Shared comparison encodings, mode constants and a saturating-increment helper
// used by counters across the design.
package cmp_pkg;

   localparam logic [1:0] CMP_NONE = 2'd0;
   localparam logic [1:0] CMP_LT   = 2'd1;
   localparam logic [1:0] CMP_EQ   = 2'd2;
   localparam logic [1:0] CMP_GT   = 2'd3;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   // Callers zero-extend to 32 bits and pass their own all-ones limit.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] limit);
      return (value == limit) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare of two WIDTH-bit operands in signed or
// unsigned mode, producing one-hot lt/eq/gt and the absolute difference.
module cmp_core
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic [WIDTH-1:0] diff
);

   logic             a_ext;
   logic             b_ext;
   logic [WIDTH:0]   sub;

   always_comb begin
      a_ext = 1'b0;
      b_ext = 1'b0;
      case (signed_mode)
         MODE_SIGNED: begin
            a_ext = a[WIDTH-1];
            b_ext = b[WIDTH-1];
         end
         MODE_UNSIGNED: begin
            a_ext = 1'b0;
            b_ext = 1'b0;
         end
         default: ;
      endcase
   end

   // One extra bit makes the subtraction exact for both modes, so its sign is lt.
   assign sub = {a_ext, a} - {b_ext, b};
   assign lt  = sub[WIDTH];
   assign eq  = (sub == '0);
   assign gt  = !lt && !eq;

   // The true magnitude is below 2^WIDTH, so modular WIDTH-bit subtraction is exact.
   assign diff = lt ? (b - a) : (a - b);

endmodule

// File: rtl/cmp_pipe_tracker.sv
// Registered compare stage with valid/ready handshake, a saturating A<B counter
// and a running maximum of |a-b| over accepted transactions.
module cmp_pipe_tracker
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic [WIDTH-1:0] diff,
   output logic [CNT_W-1:0] lt_count,
   output logic [WIDTH-1:0] max_diff
);

   localparam logic [31:0] CNT_LIMIT = 32'({CNT_W{1'b1}});

   logic             core_lt;
   logic             core_eq;
   logic             core_gt;
   logic [WIDTH-1:0] core_diff;

   logic             out_valid_q, out_valid_d;
   logic [1:0]       res_q,       res_d;
   logic [WIDTH-1:0] diff_q,      diff_d;
   logic [CNT_W-1:0] lt_count_q,  lt_count_d;
   logic [WIDTH-1:0] max_diff_q,  max_diff_d;

   logic             accept;
   logic [CNT_W-1:0] cnt_base;
   logic [WIDTH-1:0] max_base;

   cmp_core #(.WIDTH(WIDTH)) u_core (
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .lt          (core_lt),
      .eq          (core_eq),
      .gt          (core_gt),
      .diff        (core_diff)
   );

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      res_d       = res_q;
      diff_d      = diff_q;

      if (accept) begin
         out_valid_d = 1'b1;
         diff_d      = core_diff;
         res_d       = core_lt ? CMP_LT : (core_eq ? CMP_EQ : CMP_GT);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // A same-cycle clear zeroes the statistics before the accepted pair is folded in.
   always_comb begin
      cnt_base   = clear ? '0 : lt_count_q;
      max_base   = clear ? '0 : max_diff_q;
      lt_count_d = cnt_base;
      max_diff_d = max_base;

      if (accept) begin
         if (core_lt) begin
            lt_count_d = CNT_W'(sat_inc(32'(cnt_base), CNT_LIMIT));
         end
         if (core_diff > max_base) begin
            max_diff_d = core_diff;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         res_q       <= CMP_NONE;
         diff_q      <= '0;
         lt_count_q  <= '0;
         max_diff_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         diff_q      <= diff_d;
         lt_count_q  <= lt_count_d;
         max_diff_q  <= max_diff_d;
      end
   end

   assign out_valid = out_valid_q;
   assign lt        = (res_q == CMP_LT);
   assign eq        = (res_q == CMP_EQ);
   assign gt        = (res_q == CMP_GT);
   assign diff      = diff_q;
   assign lt_count  = lt_count_q;
   assign max_diff  = max_diff_q;

   // core_gt is implied by !lt && !eq; keep it observed so the port is not dangling.
   logic unused_ok;
   assign unused_ok = core_gt;

endmodule

// File: tb/tb_cmp_pipe_tracker.sv
// Directed-vector bench for cmp_pipe_tracker (WIDTH=8, CNT_W=4) with
// hand-computed expectations.
module tb_cmp_pipe_tracker;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       signed_mode;
   logic       out_valid;
   logic       out_ready;
   logic       lt, eq, gt;
   logic [7:0] diff;
   logic [3:0] lt_count;
   logic [7:0] max_diff;

   int total;
   int bad;

   cmp_pipe_tracker #(.WIDTH(8), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .lt          (lt),
      .eq          (eq),
      .gt          (gt),
      .diff        (diff),
      .lt_count    (lt_count),
      .max_diff    (max_diff)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic sm);
      in_valid    = 1'b1;
      a           = av;
      b           = bv;
      signed_mode = sm;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic expect_res(input string tag, input logic el, input logic ee, input logic eg,
                             input logic [7:0] ed, input logic [3:0] ec, input logic [7:0] em);
      check({tag, ".valid"}, out_valid, 1);
      check({tag, ".flags"}, {lt, eq, gt}, {el, ee, eg});
      check({tag, ".diff"}, diff, ed);
      check({tag, ".cnt"}, lt_count, ec);
      check({tag, ".max"}, max_diff, em);
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst_n       = 1'b0;
      clear       = 1'b0;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      signed_mode = 1'b0;
      out_ready   = 1'b1;

      #2;
      check("rst.valid", out_valid, 0);
      check("rst.flags", {lt, eq, gt}, 3'b000);
      check("rst.diff", diff, 0);
      check("rst.cnt", lt_count, 0);
      check("rst.max", max_diff, 0);
      #10 rst_n = 1'b1;
      #1;
      check("rst.in_ready", in_ready, 1);
      step();

      // 1: unsigned 3 < 200
      drive(8'd3, 8'd200, 1'b0);
      step();
      expect_res("t1", 1, 0, 0, 8'd197, 4'd1, 8'd197);

      // 2: signed -128 < 127, then same pair unsigned
      drive(8'h80, 8'h7F, 1'b1);
      step();
      expect_res("t2s", 1, 0, 0, 8'd255, 4'd2, 8'd255);
      drive(8'h80, 8'h7F, 1'b0);
      step();
      expect_res("t2u", 0, 0, 1, 8'd1, 4'd2, 8'd255);
      idle();
      step();
      check("t2.drain", out_valid, 0);

      // 3: back-pressure
      out_ready = 1'b0;
      drive(8'd10, 8'd20, 1'b0);
      step();
      expect_res("t3p1", 1, 0, 0, 8'd10, 4'd3, 8'd255);
      drive(8'd60, 8'd40, 1'b0);
      #1 check("t3.ready_p2", in_ready, 0);
      step();
      expect_res("t3hold_a", 1, 0, 0, 8'd10, 4'd3, 8'd255);
      drive(8'd7, 8'd7, 1'b0);
      #1 check("t3.ready_p3", in_ready, 0);
      step();
      expect_res("t3hold_b", 1, 0, 0, 8'd10, 4'd3, 8'd255);
      out_ready = 1'b1;
      drive(8'd60, 8'd40, 1'b0);
      #1 check("t3.ready_rel", in_ready, 1);
      step();
      expect_res("t3p2", 0, 0, 1, 8'd20, 4'd3, 8'd255);
      drive(8'd7, 8'd7, 1'b0);
      step();
      expect_res("t3p3", 0, 1, 0, 8'd0, 4'd3, 8'd255);
      idle();
      step();
      check("t3.drain", out_valid, 0);

      // 4: saturation then clear with accept
      for (int i = 0; i < 20; i++) begin
         drive(8'd0, 8'd1, 1'b0);
         step();
         check($sformatf("t4.cnt%0d", i), lt_count, (4 + i > 15) ? 15 : 4 + i);
      end
      clear = 1'b1;
      drive(8'd0, 8'd7, 1'b0);
      step();
      clear = 1'b0;
      expect_res("t4clr", 1, 0, 0, 8'd7, 4'd1, 8'd7);
      clear = 1'b1;
      idle();
      step();
      clear = 1'b0;
      check("t4.clr_only_cnt", lt_count, 0);
      check("t4.clr_only_max", max_diff, 0);

      // 5: equality and boundaries
      drive(8'd0, 8'd0, 1'b0);
      step();
      expect_res("t5z", 0, 1, 0, 8'd0, 4'd0, 8'd0);
      drive(8'd255, 8'd255, 1'b0);
      step();
      expect_res("t5f", 0, 1, 0, 8'd0, 4'd0, 8'd0);
      drive(8'd255, 8'd0, 1'b0);
      step();
      expect_res("t5u", 0, 0, 1, 8'd255, 4'd0, 8'd255);
      drive(8'hFF, 8'h00, 1'b1);
      step();
      expect_res("t5s", 1, 0, 0, 8'd1, 4'd1, 8'd255);

      // 6: async reset while holding a result
      rst_n = 1'b0;
      #1;
      check("t6.valid", out_valid, 0);
      check("t6.cnt", lt_count, 0);
      check("t6.max", max_diff, 0);
      idle();
      #1 rst_n = 1'b1;
      step();
      check("t6.in_ready", in_ready, 1);
      check("t6.valid_after", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got stuck expected finish");
      $fatal(1, "timeout");
   end

endmodule
